// File: rtl/vga_timing_pkg.sv
// ----------------------------------------------------------------------------
// vga_timing_pkg
//   Shared definitions for the 1280x1024@60 Hz raster generator:
//     - VESA horizontal/vertical timing constants (pixels / lines)
//     - coord_t : 11-bit pixel coordinate type used on the x/y outputs
//     - state_e : PLL lock qualification states
//     - in_window() : half-open range test used by the sync decoders
// ----------------------------------------------------------------------------
package vga_timing_pkg;

    // Horizontal timing, in pixel clocks
    localparam int unsigned H_ACTIVE = 1280;
    localparam int unsigned H_FP     = 48;
    localparam int unsigned H_SYNC   = 112;
    localparam int unsigned H_BP     = 248;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;  // 1688

    // Vertical timing, in lines
    localparam int unsigned V_ACTIVE = 1024;
    localparam int unsigned V_FP     = 1;
    localparam int unsigned V_SYNC   = 3;
    localparam int unsigned V_BP     = 38;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;  // 1066

    // Coordinate width seen by the pixel pipeline
    localparam int unsigned COORD_W  = 11;
    typedef logic [COORD_W-1:0] coord_t;

    // Lock qualification state machine
    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } state_e;

    // True when lo <= pos < lo+len. Evaluated at 32 bits so a window that
    // ends exactly at the counter's wrap value does not overflow.
    function automatic logic in_window(input logic [31:0] pos,
                                       input int unsigned lo,
                                       input int unsigned len);
        return (pos >= lo) && (pos < (lo + len));
    endfunction

endpackage

// File: rtl/vga_lock_qual.sv
// ----------------------------------------------------------------------------
// vga_lock_qual
//   Qualifies the PLL lock indication before the raster is allowed to run.
//   pll_locked is asynchronous to clk, so it first crosses a 2-flop
//   synchronizer. The synchronized level must then stay high for LOCK_WAIT
//   consecutive cycles in SETTLE before RUN is entered. Any low cycle drops
//   back to WAIT_LOCK, which restarts the settle count.
//
//   Ports:
//     clk_i         pixel clock
//     rst_ni        synchronous active-low reset
//     pll_locked_i  raw PLL locked (asynchronous)
//     run_o         registered, high while the FSM is in RUN
// ----------------------------------------------------------------------------
module vga_lock_qual
    import vga_timing_pkg::*;
#(
    parameter int unsigned LOCK_WAIT = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pll_locked_i,
    output logic run_o
);

    localparam int unsigned CW = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;

    if (LOCK_WAIT < 1) begin : g_lock_wait_err
        $error("vga_lock_qual: LOCK_WAIT must be at least 1");
    end

    logic [1:0]    sync_q;
    logic          lk_s;
    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          run_q;

    // Two-stage synchronizer; lk_s is the only consumer of pll_locked_i.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_locked_i};
        end
    end

    assign lk_s = sync_q[1];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            unique case (state_q)
                WAIT_LOCK: begin
                    run_q <= 1'b0;
                    if (lk_s) begin
                        state_q <= SETTLE;
                        cnt_q   <= '0;
                    end
                end
                SETTLE: begin
                    if (!lk_s) begin
                        // A glitch throws away the partial settle count.
                        state_q <= WAIT_LOCK;
                        cnt_q   <= '0;
                    end else if (32'(cnt_q) == LOCK_WAIT - 1) begin
                        state_q <= RUN;
                        run_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RUN: begin
                    if (!lk_s) begin
                        state_q <= WAIT_LOCK;
                        run_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= WAIT_LOCK;
                    cnt_q   <= '0;
                    run_q   <= 1'b0;
                end
            endcase
        end
    end

    assign run_o = run_q;

endmodule

// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
//   Raster timing generator for the pixel pipeline and DAC. Waits for a
//   qualified PLL lock, then walks h/v counters over the VESA 1280x1024@60
//   raster and decodes sync, data-enable, coordinates and line/frame strobes.
//   Every output is a flop: counter state at cycle n shows up at cycle n+1.
//   Outside RUN the counters sit at 0 and all outputs hold reset values, so
//   sync is never driven active and a lost lock cuts any pulse short.
//
//   Ports:
//     clk          108 MHz pixel clock
//     rst_n        synchronous active-low reset
//     pll_locked   PLL lock (asynchronous to clk)
//     hsync/vsync  sync outputs, active level HS_POL / VS_POL
//     de           high in the visible region
//     x, y         pixel coordinates while de, 0 otherwise
//     line_start   1-cycle pulse at h=0 of each line
//     frame_start  1-cycle pulse at h=0, v=0
//     running      high while the raster is running
// ----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE  = vga_timing_pkg::H_ACTIVE,
    parameter int unsigned H_FP      = vga_timing_pkg::H_FP,
    parameter int unsigned H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BP      = vga_timing_pkg::H_BP,
    parameter int unsigned V_ACTIVE  = vga_timing_pkg::V_ACTIVE,
    parameter int unsigned V_FP      = vga_timing_pkg::V_FP,
    parameter int unsigned V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BP      = vga_timing_pkg::V_BP,
    parameter bit          HS_POL    = 1'b1,
    parameter bit          VS_POL    = 1'b1,
    parameter int unsigned LOCK_WAIT = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pll_locked,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   de,
    output vga_timing_pkg::coord_t x,
    output vga_timing_pkg::coord_t y,
    output logic                   line_start,
    output logic                   frame_start,
    output logic                   running
);

    import vga_timing_pkg::*;

    localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW    = $clog2(H_TOT);
    localparam int unsigned VW    = $clog2(V_TOT);

    if (HW > COORD_W || VW > COORD_W) begin : g_width_err
        $error("vga_timing_gen: raster does not fit 11-bit counters");
    end

    // ------------------------------------------------------------------
    // Lock qualification
    // ------------------------------------------------------------------
    logic run;

    vga_lock_qual #(
        .LOCK_WAIT (LOCK_WAIT)
    ) u_lock_qual (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .pll_locked_i (pll_locked),
        .run_o        (run)
    );

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [31:0]   h_ext, v_ext;

    assign h_ext = 32'(h_q);
    assign v_ext = 32'(v_q);

    // Counters collapse to 0 whenever run is low, so a re-lock always
    // restarts the raster at the top-left corner.
    always_comb begin
        h_d = '0;
        v_d = '0;
        if (run) begin
            if (h_ext == H_TOT - 1) begin
                h_d = '0;
                v_d = (v_ext == V_TOT - 1) ? '0 : v_q + VW'(1);
            end else begin
                h_d = h_q + HW'(1);
                v_d = v_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Region decode from the current counters
    // ------------------------------------------------------------------
    logic de_c, hs_c, vs_c, h0_c, v0_c;

    assign de_c = (h_ext < H_ACTIVE) && (v_ext < V_ACTIVE);
    assign hs_c = in_window(h_ext, H_ACTIVE + H_FP, H_SYNC);
    // v only moves on the h wrap, so vsync edges land on h=0 by construction.
    assign vs_c = in_window(v_ext, V_ACTIVE + V_FP, V_SYNC);
    assign h0_c = (h_q == '0);
    assign v0_c = (v_q == '0);

    logic   hsync_d, vsync_d, de_d, ls_d, fs_d;
    coord_t x_d, y_d;

    always_comb begin
        hsync_d = (run && hs_c) ? HS_POL : ~HS_POL;
        vsync_d = (run && vs_c) ? VS_POL : ~VS_POL;
        de_d    = run && de_c;
        x_d     = de_d ? COORD_W'(h_q) : '0;
        y_d     = de_d ? COORD_W'(v_q) : '0;
        ls_d    = run && h0_c;
        fs_d    = run && h0_c && v0_c;
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic   hsync_q, vsync_q, de_q, ls_q, fs_q, running_q;
    coord_t x_q, y_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_q       <= '0;
            v_q       <= '0;
            hsync_q   <= ~HS_POL;
            vsync_q   <= ~VS_POL;
            de_q      <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            ls_q      <= 1'b0;
            fs_q      <= 1'b0;
            running_q <= 1'b0;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            de_q      <= de_d;
            x_q       <= x_d;
            y_q       <= y_d;
            ls_q      <= ls_d;
            fs_q      <= fs_d;
            running_q <= run;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign running     = running_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_gen
//   Two instances share clock, reset and pll_locked: the full VESA raster
//   (index 0) and a shrunken raster with inverted sync polarity and a short
//   lock wait (index 1) so that whole frames fit in a short run. A time-based
//   model predicts every output of both instances on every cycle; literal
//   checks pin the model to hand-computed VESA numbers.
// ----------------------------------------------------------------------------
module tb_vga_timing_gen;

    logic clk        = 1'b0;
    logic rst_n      = 1'b0;
    logic pll_locked = 1'b0;

    always #5 clk = ~clk;

    logic        hs[2], vs[2], de[2], ls[2], fs[2], rn[2];
    logic [10:0] xo[2], yo[2];

    vga_timing_gen u_vesa (
        .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked),
        .hsync(hs[0]), .vsync(vs[0]), .de(de[0]), .x(xo[0]), .y(yo[0]),
        .line_start(ls[0]), .frame_start(fs[0]), .running(rn[0])
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(2),
        .HS_POL(1'b0), .VS_POL(1'b0), .LOCK_WAIT(5)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked),
        .hsync(hs[1]), .vsync(vs[1]), .de(de[1]), .x(xo[1]), .y(yo[1]),
        .line_start(ls[1]), .frame_start(fs[1]), .running(rn[1])
    );

    // Model parameters per instance
    int p_ha[2] = '{1280, 16};
    int p_hf[2] = '{48, 2};
    int p_hs[2] = '{112, 3};
    int p_hb[2] = '{248, 4};
    int p_va[2] = '{1024, 6};
    int p_vf[2] = '{1, 1};
    int p_vs[2] = '{3, 2};
    int p_vb[2] = '{38, 2};
    bit p_hp[2] = '{1'b1, 1'b0};
    bit p_vp[2] = '{1'b1, 1'b0};
    int p_lw[2] = '{16, 5};

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passes++;
        else begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    function automatic int line_len(input int i);
        return p_ha[i] + p_hf[i] + p_hs[i] + p_hb[i];
    endfunction

    function automatic longint frame_len(input int i);
        return longint'(line_len(i)) * (p_va[i] + p_vf[i] + p_vs[i] + p_vb[i]);
    endfunction

    // Expected {hsync,vsync,de,x,y,line_start,frame_start,running} for a
    // raster that has been running for t cycles (t<0: not running).
    function automatic logic [27:0] exp_outs(input int i, input longint t);
        int h, v;
        logic d, ha, va;
        if (t < 0) return {~p_hp[i], ~p_vp[i], 1'b0, 11'd0, 11'd0, 3'b000};
        h  = int'(t % line_len(i));
        v  = int'(t / line_len(i));
        d  = (h < p_ha[i]) && (v < p_va[i]);
        ha = (h >= p_ha[i] + p_hf[i]) && (h < p_ha[i] + p_hf[i] + p_hs[i]);
        va = (v >= p_va[i] + p_vf[i]) && (v < p_va[i] + p_vf[i] + p_vs[i]);
        return {ha ? p_hp[i] : ~p_hp[i], va ? p_vp[i] : ~p_vp[i], d,
                d ? 11'(h) : 11'd0, d ? 11'(v) : 11'd0,
                (h == 0), (h == 0 && v == 0), 1'b1};
    endfunction

    // Model: raster runs once the synchronized lock has been high for
    // LOCK_WAIT+1 consecutive cycles (one to leave WAIT_LOCK, LOCK_WAIT in
    // SETTLE); t counts cycles since RUN was entered.
    longint      t_run[2];
    int          streak[2];
    logic        s1[2], s2[2];
    logic [27:0] exp_v[2];
    bit          started = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                s1[i] = 1'b0; s2[i] = 1'b0; streak[i] = 0; t_run[i] = -1;
                exp_v[i] = exp_outs(i, -1);
            end else begin
                exp_v[i] = exp_outs(i, t_run[i]);
                if (streak[i] >= p_lw[i] + 1)
                    t_run[i] = (t_run[i] < 0) ? 0 : (t_run[i] + 1) % frame_len(i);
                else
                    t_run[i] = -1;
                s2[i] = s1[i];
                s1[i] = pll_locked;
                streak[i] = s2[i] ? streak[i] + 1 : 0;
            end
        end
        started = 1'b1;
    end

    logic [27:0] got_v;

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                got_v = {hs[i], vs[i], de[i], xo[i], yo[i], ls[i], fs[i], rn[i]};
                checks++;
                if (got_v === exp_v[i]) passes++;
                else begin
                    fails++;
                    if (fails < 20)
                        $display("FAIL model_cmp inst%0d @%0t: got %h expected %h", i, $time, got_v, exp_v[i]);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int n, dcnt, hcnt, hfirst, lsx, vcnt, vfirst, lcnt, fs_seen;

    initial begin
        rst_n = 1'b0;
        pll_locked = 1'b1;
        repeat (4) @(negedge clk);
        lit("rst_running", rn[0], 0);
        lit("rst_hsync_vesa", hs[0], 0);
        lit("rst_vsync_vesa", vs[0], 0);
        lit("rst_hsync_small", hs[1], 1);
        lit("rst_de", de[0], 0);

        // Release reset; running must follow 2+16+1 cycles later
        rst_n = 1'b1;
        @(negedge clk);
        n = 0;
        while (!rn[0] && n < 100) begin @(negedge clk); n++; end
        lit("lock_latency", n, 19);
        lit("first_fs", fs[0], 1);
        lit("first_de", de[0], 1);
        lit("first_x", xo[0], 0);
        lit("first_y", yo[0], 0);

        // First VESA line
        dcnt = 0; hcnt = 0; hfirst = -1; lsx = 0;
        for (int k = 0; k < 1688; k++) begin
            if (de[0]) dcnt++;
            if (hs[0]) begin if (hfirst < 0) hfirst = k; hcnt++; end
            if (k > 0 && ls[0]) lsx++;
            @(negedge clk);
        end
        lit("vesa_de_len", dcnt, 1280);
        lit("vesa_hs_start", hfirst, 1328);
        lit("vesa_hs_len", hcnt, 112);
        lit("vesa_ls_inside", lsx, 0);
        lit("vesa_ls_period", ls[0], 1);
        lit("vesa_line2_y", yo[0], 1);

        // One full frame of the small raster (25 x 11)
        n = 0;
        while (!fs[1] && n < 400) begin @(negedge clk); n++; end
        lit("small_fs_found", fs[1], 1);
        dcnt = 0; vcnt = 0; vfirst = -1; lcnt = 0;
        for (int k = 0; k < 275; k++) begin
            if (de[1]) dcnt++;
            if (vs[1] == 1'b0) begin if (vfirst < 0) vfirst = k; vcnt++; end
            if (ls[1]) lcnt++;
            @(negedge clk);
        end
        lit("small_de_cycles", dcnt, 96);
        lit("small_vs_start", vfirst, 175);
        lit("small_vs_len", vcnt, 50);
        lit("small_ls_count", lcnt, 11);
        lit("small_fs_period", fs[1], 1);
        lit("small_wrap_ls", ls[1], 1);

        // Lock loss mid-frame on the small raster
        n = 0;
        while (!(de[1] && yo[1] == 3 && xo[1] == 10) && n < 600) begin @(negedge clk); n++; end
        lit("lockloss_pos_found", de[1] && yo[1] == 3 && xo[1] == 10, 1);
        pll_locked = 1'b0;
        n = 0; fs_seen = 0;
        while ((rn[1] || de[1] || hs[1] != 1'b1 || vs[1] != 1'b1) && n < 10) begin
            @(negedge clk); n++;
            if (fs[1]) fs_seen = 1;
        end
        lit("lockloss_within_4", (n >= 1 && n <= 4), 1);
        lit("lockloss_no_fs", fs_seen, 0);
        repeat (30) @(negedge clk);
        lit("lockloss_vesa_idle", rn[0], 0);

        // Re-lock
        pll_locked = 1'b1;
        @(negedge clk);
        n = 0;
        while (!rn[0] && n < 100) begin @(negedge clk); n++; end
        lit("relock_latency", n, 19);
        lit("relock_fs", fs[0], 1);
        lit("relock_ls", ls[0], 1);
        lit("relock_x", xo[0], 0);
        lit("relock_y", yo[0], 0);

        // Glitch in SETTLE restarts the count
        pll_locked = 1'b0;
        repeat (30) @(negedge clk);
        pll_locked = 1'b1;
        repeat (12) @(negedge clk);
        pll_locked = 1'b0;
        repeat (2) @(negedge clk);
        lit("glitch_not_running", rn[0], 0);
        pll_locked = 1'b1;
        @(negedge clk);
        n = 0;
        while (!rn[0] && n < 100) begin @(negedge clk); n++; end
        lit("glitch_latency", n, 19);

        // Randomized lock / reset activity, checked by the model
        for (int it = 0; it < 40; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 5) begin
                pll_locked = 1'b1;
                repeat ($urandom_range(50, 1500)) @(negedge clk);
            end else if (r < 7) begin
                pll_locked = 1'b1;
                repeat ($urandom_range(1, 25)) @(negedge clk);
            end else if (r < 9) begin
                pll_locked = 1'b0;
                repeat ($urandom_range(1, 30)) @(negedge clk);
            end else begin
                rst_n = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                rst_n = 1'b1;
            end
        end
        pll_locked = 1'b1;
        repeat (400) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
